external_interrupt_arbiter: RTL and testbench

- Collects NUM_SOURCES platform interrupt lines and applies per-source enable and priority plus a global threshold.
- Presents a single machine-external request (drives the CSR MEIP bit) and the winning external interrupt code (drives the CSR external-interrupt-code field).
- Runs a claim/complete handshake with the trap logic, so a source is not re-presented while its handler is in service.
- Sits between the IO/peripheral bus and the CSR unit; the interrupt controller consumes its outputs indirectly through the CSR.

---
 rtl/external_interrupt_arbiter_pkg.sv | 22 ++
 rtl/external_interrupt_arbiter_priority_encoder.sv | 59 +++++
 rtl/external_interrupt_arbiter.sv | 174 +++++++++++++++++
 tb/tb_external_interrupt_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/external_interrupt_arbiter_pkg.sv
// rtl/external_interrupt_arbiter_pkg.sv - shared types and constants for the external interrupt arbiter
package ExternalInterruptTypes;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESENT = 2'd1,
      SERVICE = 2'd2
   } ExtIntState;

   localparam logic [1:0] CFG_SEL_PRIO      = 2'd0;
   localparam logic [1:0] CFG_SEL_ENABLE    = 2'd1;
   localparam logic [1:0] CFG_SEL_THRESHOLD = 2'd2;
   localparam logic [1:0] CFG_SEL_RESERVED  = 2'd3;

   localparam int CODE_BASE_DEFAULT  = 16;
   localparam int PRIO_WIDTH_DEFAULT = 3;
   localparam int CODE_WIDTH_DEFAULT = 5;

   typedef logic [PRIO_WIDTH_DEFAULT-1:0] ExtIntPriorityPath;
   typedef logic [CODE_WIDTH_DEFAULT-1:0] ExtIntCodePath;

endpackage

// File: rtl/external_interrupt_arbiter_priority_encoder.sv
// rtl/external_interrupt_arbiter_priority_encoder.sv - binary comparison tree picking the highest-priority eligible source
module external_interrupt_priority_encoder #(
   parameter int NUM_SOURCES = 8,
   parameter int PRIO_WIDTH  = 3
)(
   input  logic [NUM_SOURCES-1:0]            eligible,
   input  logic [NUM_SOURCES*PRIO_WIDTH-1:0] prio,
   output logic [$clog2(NUM_SOURCES)-1:0]    winner,
   output logic                              valid
);

   localparam int IDX_WIDTH = $clog2(NUM_SOURCES);
   localparam int LEAVES    = 1 << IDX_WIDTH;

   // Pad to a power of two; padded leaves are never valid.
   logic [LEAVES-1:0]            elig_pad;
   logic [LEAVES*PRIO_WIDTH-1:0] prio_pad;

   logic                  node_valid [IDX_WIDTH+1][LEAVES];
   logic [PRIO_WIDTH-1:0] node_prio  [IDX_WIDTH+1][LEAVES];
   logic [IDX_WIDTH-1:0]  node_idx   [IDX_WIDTH+1][LEAVES];

   assign elig_pad = LEAVES'(eligible);
   assign prio_pad = (LEAVES*PRIO_WIDTH)'(prio);

   // Pairwise reduction; the right child wins only on strictly higher priority so ties favour the lower index.
   always_comb begin
      for (int l = 0; l <= IDX_WIDTH; l++) begin
         for (int n = 0; n < LEAVES; n++) begin
            node_valid[l][n] = 1'b0;
            node_prio[l][n]  = '0;
            node_idx[l][n]   = '0;
         end
      end
      for (int n = 0; n < LEAVES; n++) begin
         node_valid[0][n] = elig_pad[n];
         node_prio[0][n]  = prio_pad[n*PRIO_WIDTH +: PRIO_WIDTH];
         node_idx[0][n]   = IDX_WIDTH'(n);
      end
      for (int l = 1; l <= IDX_WIDTH; l++) begin
         for (int n = 0; n < (LEAVES >> l); n++) begin
            if (node_valid[l-1][2*n+1] &&
                (!node_valid[l-1][2*n] || (node_prio[l-1][2*n+1] > node_prio[l-1][2*n]))) begin
               node_valid[l][n] = 1'b1;
               node_prio[l][n]  = node_prio[l-1][2*n+1];
               node_idx[l][n]   = node_idx[l-1][2*n+1];
            end else begin
               node_valid[l][n] = node_valid[l-1][2*n];
               node_prio[l][n]  = node_prio[l-1][2*n];
               node_idx[l][n]   = node_idx[l-1][2*n];
            end
         end
      end
   end

   assign winner = node_idx[IDX_WIDTH][0];
   assign valid  = node_valid[IDX_WIDTH][0];

endmodule

// File: rtl/external_interrupt_arbiter.sv
// rtl/external_interrupt_arbiter.sv - external interrupt arbiter with claim/complete; EXTERNAL_INTERRUPT_EDGE_TRIGGER_EN selects edge-triggered pending
module external_interrupt_arbiter
   import ExternalInterruptTypes::*;
#(
   parameter int NUM_SOURCES = 8,
   parameter int PRIO_WIDTH  = PRIO_WIDTH_DEFAULT,
   parameter int CODE_WIDTH  = CODE_WIDTH_DEFAULT,
   parameter int CODE_BASE   = CODE_BASE_DEFAULT
)(
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_SOURCES-1:0]         irqIn,
   input  logic                           cfgWE,
   input  logic [1:0]                     cfgSel,
   input  logic [$clog2(NUM_SOURCES)-1:0] cfgIndex,
   input  logic [NUM_SOURCES-1:0]         cfgWData,
   input  logic                           claim,
   input  logic                           complete,
   input  logic [CODE_WIDTH-1:0]          completeCode,
   output logic                           meipOut,
   output logic [CODE_WIDTH-1:0]          codeOut,
   output logic                           inServiceOut
);

   localparam int IDX_WIDTH = $clog2(NUM_SOURCES);

   logic [NUM_SOURCES-1:0]            pending;
   logic [NUM_SOURCES-1:0]            enable;
   logic [NUM_SOURCES-1:0]            eligible;
   logic [PRIO_WIDTH-1:0]             prio [NUM_SOURCES];
   logic [PRIO_WIDTH-1:0]             threshold;
   logic [NUM_SOURCES*PRIO_WIDTH-1:0] prio_flat;
   logic [PRIO_WIDTH-1:0]             wdata_prio;

   ExtIntState           state;
   logic [IDX_WIDTH-1:0] svc_idx;
   logic [IDX_WIDTH-1:0] present_idx;
   logic [IDX_WIDTH-1:0] win_idx;
   logic                 win_valid;

   function automatic logic [CODE_WIDTH-1:0] code_of(input logic [IDX_WIDTH-1:0] idx);
      return CODE_WIDTH'(CODE_BASE) + CODE_WIDTH'(idx);
   endfunction

   assign wdata_prio = PRIO_WIDTH'(cfgWData);

   // Qualify each pending line; the source in service is masked so it is not re-presented.
   always_comb begin
      eligible  = '0;
      prio_flat = '0;
      for (int i = 0; i < NUM_SOURCES; i++) begin
         prio_flat[i*PRIO_WIDTH +: PRIO_WIDTH] = prio[i];
         eligible[i] = pending[i] & enable[i] & (prio[i] > threshold)
                       & ~((state == SERVICE) && (svc_idx == IDX_WIDTH'(i)));
      end
   end

   external_interrupt_priority_encoder #(
      .NUM_SOURCES (NUM_SOURCES),
      .PRIO_WIDTH  (PRIO_WIDTH)
   ) u_priority_encoder (
      .eligible (eligible),
      .prio     (prio_flat),
      .winner   (win_idx),
      .valid    (win_valid)
   );

   // Configuration registers; a write is visible to arbitration on the following cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         enable    <= '0;
         threshold <= '0;
         for (int i = 0; i < NUM_SOURCES; i++) begin
            prio[i] <= '0;
         end
      end else if (cfgWE) begin
         case (cfgSel)
            CFG_SEL_PRIO: begin
               if (int'(cfgIndex) < NUM_SOURCES) begin
                  prio[cfgIndex] <= wdata_prio;
               end
            end
            CFG_SEL_ENABLE:    enable    <= cfgWData;
            CFG_SEL_THRESHOLD: threshold <= wdata_prio;
            CFG_SEL_RESERVED:  ;
            default:           ;
         endcase
      end
   end

`ifdef EXTERNAL_INTERRUPT_EDGE_TRIGGER_EN
   logic [NUM_SOURCES-1:0] irq_prev;
   logic [NUM_SOURCES-1:0] claim_clear;

   // Claiming the presented source clears its sticky pending bit.
   always_comb begin
      claim_clear = '0;
      if ((state == PRESENT) && claim) begin
         claim_clear = NUM_SOURCES'(1) << present_idx;
      end
   end

   // Sticky rising-edge capture; a coincident edge beats the claim clear.
   always_ff @(posedge clk) begin
      if (!rst) begin
         irq_prev <= '0;
         pending  <= '0;
      end else begin
         irq_prev <= irqIn;
         pending  <= (pending & ~claim_clear) | (irqIn & ~irq_prev);
      end
   end
`else
   // Level mode: pending simply follows the synchronised lines.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pending <= '0;
      end else begin
         pending <= irqIn;
      end
   end
`endif

   // Claim/complete state machine with registered request, code and in-service outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= IDLE;
         svc_idx      <= '0;
         present_idx  <= '0;
         meipOut      <= 1'b0;
         codeOut      <= '0;
         inServiceOut <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               meipOut <= 1'b0;
               if (win_valid) begin
                  state       <= PRESENT;
                  meipOut     <= 1'b1;
                  codeOut     <= code_of(win_idx);
                  present_idx <= win_idx;
               end
            end
            PRESENT: begin
               if (claim) begin
                  state        <= SERVICE;
                  svc_idx      <= present_idx;
                  meipOut      <= 1'b0;
                  inServiceOut <= 1'b1;
               end else if (!win_valid) begin
                  state   <= IDLE;
                  meipOut <= 1'b0;
               end else begin
                  meipOut     <= 1'b1;
                  codeOut     <= code_of(win_idx);
                  present_idx <= win_idx;
               end
            end
            SERVICE: begin
               meipOut <= 1'b0;
               if (complete && (completeCode == code_of(svc_idx))) begin
                  state        <= IDLE;
                  inServiceOut <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               meipOut <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_external_interrupt_arbiter.sv
// tb/tb_external_interrupt_arbiter.sv - randomized self-checking bench against a behavioural model
module tb_external_interrupt_arbiter;

   localparam int N    = 8;
   localparam int PW   = 3;
   localparam int CW   = 5;
   localparam int IW   = 3;
   localparam int BASE = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  irqIn;
   logic          cfgWE;
   logic [1:0]    cfgSel;
   logic [IW-1:0] cfgIndex;
   logic [N-1:0]  cfgWData;
   logic          claim;
   logic          complete;
   logic [CW-1:0] completeCode;
   logic          meipOut;
   logic [CW-1:0] codeOut;
   logic          inServiceOut;

   always #5 clk = ~clk;

   external_interrupt_arbiter #(
      .NUM_SOURCES (N),
      .PRIO_WIDTH  (PW),
      .CODE_WIDTH  (CW),
      .CODE_BASE   (BASE)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .irqIn        (irqIn),
      .cfgWE        (cfgWE),
      .cfgSel       (cfgSel),
      .cfgIndex     (cfgIndex),
      .cfgWData     (cfgWData),
      .claim        (claim),
      .complete     (complete),
      .completeCode (completeCode),
      .meipOut      (meipOut),
      .codeOut      (codeOut),
      .inServiceOut (inServiceOut)
   );

   int n_vec  = 0;
   int n_miss = 0;

   // Reference model: 0 = idle, 1 = presenting, 2 = in service
   bit m_pend [N];
   bit m_prev [N];
   bit m_en   [N];
   int m_prio [N];
   int m_thr   = 0;
   int m_state = 0;
   int m_svc   = 0;
   bit m_meip  = 0;
   int m_code  = 0;
   bit m_insvc = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit model_eligible(input int i);
      return m_pend[i] && m_en[i] && (m_prio[i] > m_thr) && !(m_state == 2 && m_svc == i);
   endfunction

   // Search from the highest priority value down; first index found at that level wins.
   function automatic int model_winner();
      int w = -1;
      for (int p = (1 << PW) - 1; p > 0 && w < 0; p--) begin
         for (int i = 0; i < N; i++) begin
            if (w < 0 && model_eligible(i) && m_prio[i] == p) w = i;
         end
      end
      return w;
   endfunction

   task automatic model_step();
      int w;
      bit nxt [N];
      if (!rst) begin
         for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; m_prev[i] = 0; m_en[i] = 0; m_prio[i] = 0;
         end
         m_thr = 0; m_state = 0; m_svc = 0; m_meip = 0; m_code = 0; m_insvc = 0;
         return;
      end
      w = model_winner();
      for (int i = 0; i < N; i++) begin
`ifdef EXTERNAL_INTERRUPT_EDGE_TRIGGER_EN
         nxt[i] = (irqIn[i] && !m_prev[i]) ||
                  (m_pend[i] && !(m_state == 1 && claim && i == m_code - BASE));
         m_prev[i] = irqIn[i];
`else
         nxt[i] = irqIn[i];
`endif
      end
      m_pend = nxt;
      case (m_state)
         0: if (w >= 0) begin
               m_state = 1; m_meip = 1; m_code = BASE + w;
            end
         1: if (claim) begin
               m_state = 2; m_svc = m_code - BASE; m_meip = 0; m_insvc = 1;
            end else if (w < 0) begin
               m_state = 0; m_meip = 0;
            end else begin
               m_code = BASE + w;
            end
         default: if (complete && int'(completeCode) == BASE + m_svc) begin
               m_state = 0; m_insvc = 0;
            end
      endcase
      if (cfgWE) begin
         case (cfgSel)
            2'd0: m_prio[cfgIndex] = int'(cfgWData) & 7;
            2'd1: for (int i = 0; i < N; i++) m_en[i] = cfgWData[i];
            2'd2: m_thr = int'(cfgWData) & 7;
            default: ;
         endcase
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_val("meipOut", meipOut, m_meip);
      check_val("codeOut", codeOut, m_code);
      check_val("inServiceOut", inServiceOut, m_insvc);
   endtask

   task automatic cfg_write(input int sel, input int idx, input int data);
      cfgWE    = 1'b1;
      cfgSel   = 2'(sel);
      cfgIndex = IW'(idx);
      cfgWData = N'(data);
      cycle();
      cfgWE    = 1'b0;
   endtask

   initial begin
      int b;
      rst = 1'b0; irqIn = '0; cfgWE = 1'b0; cfgSel = '0; cfgIndex = '0; cfgWData = '0;
      claim = 1'b0; complete = 1'b0; completeCode = '0;
      cycle(); cycle();
      check_val("rst_meip", meipOut, 0);
      check_val("rst_code", codeOut, 0);
      check_val("rst_insvc", inServiceOut, 0);
      rst = 1'b1;

      cfg_write(1, 0, 8'hFF);
      cfg_write(0, 3, 2);
      cfg_write(2, 0, 0);
      irqIn = 8'h08;
      cycle();
      check_val("lat1_meip", meipOut, 0);
      cycle();
      check_val("lat2_meip", meipOut, 1);
      check_val("lat2_code", codeOut, 19);

      cfg_write(0, 5, 7);
      irqIn = 8'h28;
      cycle(); cycle();
      check_val("preempt_code", codeOut, 21);
      claim = 1'b1; cycle(); claim = 1'b0;
      check_val("claim_insvc", inServiceOut, 1);
      check_val("claim_meip", meipOut, 0);
      complete = 1'b1; completeCode = 5'd19; cycle(); complete = 1'b0;
      check_val("badcomplete_insvc", inServiceOut, 1);
      irqIn = 8'h08;
      complete = 1'b1; completeCode = 5'd21; cycle(); complete = 1'b0;
      check_val("complete_insvc", inServiceOut, 0);
      check_val("complete_meip", meipOut, 0);
      cycle();
      check_val("represent_meip", meipOut, 1);
      check_val("represent_code", codeOut, 19);

      cfg_write(0, 1, 5);
      cfg_write(0, 6, 5);
      irqIn = 8'h4A;
      cycle(); cycle();
      check_val("tie_code", codeOut, 17);

      irqIn = 8'h08;
      cfg_write(2, 0, 2);
      cycle(); cycle(); cycle();
      check_val("thr_block_meip", meipOut, 0);
      cfg_write(2, 0, 1);
      check_val("thr_wr1_meip", meipOut, 0);
      cycle();
      check_val("thr_wr2_meip", meipOut, 1);
      check_val("thr_wr2_code", codeOut, 19);

      claim = 1'b1; cycle(); claim = 1'b0;
      check_val("svc_before_rst", inServiceOut, 1);
      rst = 1'b0; cycle(); rst = 1'b1;
      check_val("midrst_meip", meipOut, 0);
      check_val("midrst_code", codeOut, 0);
      check_val("midrst_insvc", inServiceOut, 0);
      cycle(); cycle(); cycle();
      check_val("cfg_dropped_meip", meipOut, 0);

`ifdef EXTERNAL_INTERRUPT_EDGE_TRIGGER_EN
      irqIn = '0;
      cfg_write(1, 0, 8'hFF);
      cfg_write(0, 2, 3);
      irqIn = 8'h04; cycle(); irqIn = '0; cycle();
      check_val("edge_meip", meipOut, 1);
      check_val("edge_code", codeOut, 18);
      cycle(); cycle();
      check_val("edge_held_meip", meipOut, 1);
      claim = 1'b1; cycle(); claim = 1'b0;
      complete = 1'b1; completeCode = 5'd18; cycle(); complete = 1'b0;
      cycle();
      check_val("edge_cleared_meip", meipOut, 0);
      irqIn = 8'h04; cycle(); irqIn = '0; cycle();
      irqIn = 8'h04; claim = 1'b1; cycle(); claim = 1'b0; irqIn = '0;
      check_val("edge_coinc_insvc", inServiceOut, 1);
      complete = 1'b1; completeCode = 5'd18; cycle(); complete = 1'b0;
      cycle();
      check_val("edge_coinc_meip", meipOut, 1);
      check_val("edge_coinc_code", codeOut, 18);
`endif

      for (int k = 0; k < 4000; k++) begin
         rst = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 3) == 0) begin
            b = int'($urandom_range(0, N - 1));
            irqIn[b] = ~irqIn[b];
         end
         cfgWE    = ($urandom_range(0, 5) == 0);
         cfgSel   = 2'($urandom_range(0, 3));
         cfgIndex = IW'($urandom_range(0, N - 1));
         if (cfgSel == 2'd2)      cfgWData = N'($urandom_range(0, 3));
         else if (cfgSel == 2'd1) cfgWData = N'($urandom | $urandom);
         else                     cfgWData = N'($urandom);
         claim    = ($urandom_range(0, 3) == 0);
         complete = ($urandom_range(0, 3) == 0);
         completeCode = ($urandom_range(0, 1) == 0) ? CW'(BASE + m_svc) : CW'($urandom_range(0, 31));
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
